// File: rtl/gng_rom_pkg.sv
// Shared types and constants for the ROM-load router: region codes, region map,
// ROM signature bytes and the write-transaction payload.
package gng_rom_pkg;

   localparam int unsigned BYTE_AW = 25;
   localparam int unsigned TXN_AW  = 17;

   typedef enum logic [2:0] {
      REG_MAIN = 3'd0,
      REG_SND  = 3'd1,
      REG_CHAR = 3'd2,
      REG_SCR  = 3'd3,
      REG_OBJ  = 3'd4,
      REG_PROM = 3'd5
   } region_e;

   localparam logic [BYTE_AW-1:0] MAIN_BASE = 25'h000_0000;
   localparam logic [BYTE_AW-1:0] SND_BASE  = 25'h001_8000;
   localparam logic [BYTE_AW-1:0] CHAR_BASE = 25'h002_0000;
   localparam logic [BYTE_AW-1:0] SCR_BASE  = 25'h002_4000;
   localparam logic [BYTE_AW-1:0] OBJ_BASE  = 25'h003_C000;
   localparam logic [BYTE_AW-1:0] PROM_BASE = 25'h004_C000;
   localparam logic [BYTE_AW-1:0] ROM_END   = 25'h004_C400;

   localparam logic [7:0] SIG_B0 = 8'h10;
   localparam logic [7:0] SIG_B1 = 8'h83;
   localparam logic [7:0] SIG_B2 = 8'h00;
   localparam logic [7:0] SIG_B3 = 8'h80;

   typedef struct packed {
      region_e             region;
      logic [TXN_AW-1:0]   addr;
      logic [15:0]         data;
      logic [1:0]          be;
   } wr_txn_t;

   typedef struct packed {
      logic                hit;
      region_e             region;
      logic [TXN_AW-1:0]   waddr;
   } dec_t;

   // Map the even-slot byte address to a region and region-relative word address.
   function automatic dec_t decode_region(input logic [BYTE_AW-1:0] a);
      dec_t                d;
      logic [BYTE_AW-1:0]  base;
      d.hit = 1'b1;
      if (a < SND_BASE) begin
         d.region = REG_MAIN; base = MAIN_BASE;
      end else if (a < CHAR_BASE) begin
         d.region = REG_SND;  base = SND_BASE;
      end else if (a < SCR_BASE) begin
         d.region = REG_CHAR; base = CHAR_BASE;
      end else if (a < OBJ_BASE) begin
         d.region = REG_SCR;  base = SCR_BASE;
      end else if (a < PROM_BASE) begin
         d.region = REG_OBJ;  base = OBJ_BASE;
      end else if (a < ROM_END) begin
         d.region = REG_PROM; base = PROM_BASE;
      end else begin
         d.hit    = 1'b0;
         d.region = REG_MAIN; base = MAIN_BASE;
      end
      d.waddr = TXN_AW'((a - base) >> 1);
      return d;
   endfunction

   function automatic logic [7:0] sig_byte(input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = SIG_B0;
         2'd1:    b = SIG_B1;
         2'd2:    b = SIG_B2;
         default: b = SIG_B3;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/gng_wr_fifo.sv
// Show-ahead FIFO of write transactions; a push while full is accepted only
// when a pop happens in the same cycle.
module gng_wr_fifo
   import gng_rom_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk_sys,
   input  logic                      rst_n,
   input  logic                      push,
   input  wr_txn_t                   din,
   input  logic                      pop,
   output wr_txn_t                   dout,
   output logic                      empty,
   output logic                      full,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   wr_txn_t           mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     cnt_q;
   logic              do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem_q[rd_ptr_q];
   assign count   = cnt_q;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= din;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/gng_romload_router.sv
// Turns the HPS download byte stream into region-tagged 16-bit write
// transactions, tracks download completion and detects the ROM signature.
module gng_romload_router
   import gng_rom_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned WADDR_W    = 17
) (
   input  logic                clk_sys,
   input  logic                rst_n,
   input  logic                ioctl_download,
   input  logic                ioctl_wr,
   input  logic [24:0]         ioctl_addr,
   input  logic [7:0]          ioctl_dout,
   output logic                wr_valid,
   input  logic                wr_ready,
   output logic [2:0]          wr_region,
   output logic [WADDR_W-1:0]  wr_addr,
   output logic [15:0]         wr_data,
   output logic [1:0]          wr_be,
   output logic                busy,
   output logic                rom_done,
   output logic                inv_ena,
   output logic                overflow
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic                dl_q;
   logic                pend_vld_q, pend_vld_d;
   logic [24:0]         pend_addr_q, pend_addr_d;
   logic [7:0]          pend_data_q, pend_data_d;
   logic [3:0]          sig_q, sig_d;
   logic                inv_q;
   logic                seen_q, seen_d;
   logic                rom_done_q, rom_done_d;
   logic                ovf_q, ovf_d;

   logic                dl_start, dl_fall, pend_live, merge;
   logic                push_c;
   logic [24:0]         push_addr;
   logic [15:0]         push_data;
   logic [1:0]          push_be;
   dec_t                dec;
   wr_txn_t             fifo_din, fifo_dout;
   logic                fifo_push, fifo_pop, fifo_empty, fifo_full;
   logic [CW-1:0]       fifo_count;

   assign dl_start  = ioctl_download & ~dl_q;
   assign dl_fall   = ~ioctl_download & dl_q;
   assign pend_live = pend_vld_q & ~dl_start;
   assign merge     = ioctl_wr & pend_live & ~pend_addr_q[0] &
                      (ioctl_addr == pend_addr_q + 25'd1);

   // Byte packer: merge an even/odd pair, otherwise emit the old byte alone.
   always_comb begin
      pend_vld_d  = pend_live;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;
      push_c      = 1'b0;
      push_addr   = {pend_addr_q[24:1], 1'b0};
      push_data   = pend_addr_q[0] ? {pend_data_q, 8'h00} : {8'h00, pend_data_q};
      push_be     = pend_addr_q[0] ? 2'b10 : 2'b01;
      if (ioctl_wr) begin
         if (merge) begin
            push_c     = 1'b1;
            push_data  = {ioctl_dout, pend_data_q};
            push_be    = 2'b11;
            pend_vld_d = 1'b0;
         end else begin
            push_c      = pend_live;
            pend_vld_d  = 1'b1;
            pend_addr_d = ioctl_addr;
            pend_data_d = ioctl_dout;
         end
      end else if (dl_fall & pend_vld_q) begin
         push_c     = 1'b1;
         pend_vld_d = 1'b0;
      end
   end

   assign dec       = decode_region(push_addr);
   assign fifo_push = push_c & dec.hit;
   assign fifo_pop  = ~fifo_empty & wr_ready;

   always_comb begin
      fifo_din        = '0;
      fifo_din.region = dec.region;
      fifo_din.addr   = dec.waddr;
      fifo_din.data   = push_data;
      fifo_din.be     = push_be;
   end

   // Status flags: overflow, signature, completion.
   always_comb begin
      ovf_d      = (ovf_q & ~dl_start) | (fifo_push & fifo_full & ~fifo_pop);
      sig_d      = dl_start ? 4'b0000 : sig_q;
      if (ioctl_wr && (ioctl_addr < 25'd4))
         sig_d[ioctl_addr[1:0]] = (ioctl_dout == sig_byte(ioctl_addr[1:0]));
      seen_d     = seen_q | dl_start;
      rom_done_d = dl_start ? 1'b0 :
                   (rom_done_q | (seen_q & ~ioctl_download & ~pend_vld_q & fifo_empty));
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         dl_q        <= 1'b0;
         pend_vld_q  <= 1'b0;
         pend_addr_q <= '0;
         pend_data_q <= '0;
         sig_q       <= '0;
         inv_q       <= 1'b0;
         seen_q      <= 1'b0;
         rom_done_q  <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         dl_q        <= ioctl_download;
         pend_vld_q  <= pend_vld_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
         sig_q       <= sig_d;
         inv_q       <= &sig_q;
         seen_q      <= seen_d;
         rom_done_q  <= rom_done_d;
         ovf_q       <= ovf_d;
      end
   end

   gng_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .push    (fifo_push),
      .din     (fifo_din),
      .pop     (fifo_pop),
      .dout    (fifo_dout),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .count   (fifo_count)
   );

   assign wr_valid  = ~fifo_empty;
   assign wr_region = fifo_dout.region;
   assign wr_addr   = WADDR_W'(fifo_dout.addr);
   assign wr_data   = fifo_dout.data;
   assign wr_be     = fifo_dout.be;
   assign busy      = pend_vld_q | (fifo_count != '0);
   assign rom_done  = rom_done_q;
   assign inv_ena   = inv_q;
   assign overflow  = ovf_q;

endmodule
